chip8_pdm_decimator: RTL and testbench

- Receive side of the CHIP-8 audio path: clocks an external PDM microphone and samples its 1-bit stream.
- Decimates the stream with a boxcar (ones-count) filter into signed 8-bit PCM samples, at the same rate the audio generator produces them.
- Delivers samples over a valid/ready handshake to downstream consumers (sound-detect logic, loopback checker).
- Sits between the mic pins and the audio/keypad control logic.

---
 rtl/chip8_audio_pkg.sv | 23 ++
 rtl/chip8_mic_clk_gen.sv | 40 ++++
 rtl/chip8_pdm_decimator.sv | 111 +++++++++++
 tb/tb_chip8_pdm_decimator.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/chip8_audio_pkg.sv
// Shared audio-path definitions: one PDM rate for the generator and the
// decimator, the PCM sample type and the decimator state encoding.
package chip8_audio_pkg;

  localparam int PDM_COUNT_PERIOD_DFLT = 32;
  localparam int NUM_PDM_SAMPLES_DFLT  = 1024;

  typedef logic signed [7:0] pcm_t;

  typedef enum logic [1:0] {
    DISABLED = 2'd0,
    WARMUP   = 2'd1,
    RUN      = 2'd2
  } dec_state_t;

  // Clamp a widened PCM value into the 8-bit signed range.
  function automatic pcm_t saturate_pcm(input logic signed [9:0] wide);
    if (wide > 10'sd127) return 8'sh7f;
    if (wide < -10'sd128) return 8'sh80;
    return pcm_t'(wide[7:0]);
  endfunction

endpackage

// File: rtl/chip8_mic_clk_gen.sv
// PDM microphone clock divider: registered 50%-duty mic clock plus a
// one-cycle tick coinciding with each rising edge of that clock.
module chip8_mic_clk_gen #(
  parameter int PDM_COUNT_PERIOD = 32
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic enable_in,
  output logic mic_clk_out,
  output logic pdm_tick
);

  localparam int CNT_W = $clog2(PDM_COUNT_PERIOD);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PDM_COUNT_PERIOD - 1);
  localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(PDM_COUNT_PERIOD / 2);

  logic [CNT_W-1:0] clk_cnt;
  logic             mic_clk_next;

  assign mic_clk_next = (clk_cnt < HALF_CNT);

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      clk_cnt     <= '0;
      mic_clk_out <= 1'b0;
      pdm_tick    <= 1'b0;
    end else if (!enable_in) begin
      clk_cnt     <= '0;
      mic_clk_out <= 1'b0;
      pdm_tick    <= 1'b0;
    end else begin
      clk_cnt     <= (clk_cnt == LAST_CNT) ? '0 : clk_cnt + CNT_W'(1);
      mic_clk_out <= mic_clk_next;
      pdm_tick    <= mic_clk_next & ~mic_clk_out;
    end
  end

endmodule

// File: rtl/chip8_pdm_decimator.sv
// PDM microphone receiver: synchronizes the mic bit, boxcar-decimates each
// window of PDM ticks into a signed 8-bit sample and hands it off valid/ready.
module chip8_pdm_decimator
  import chip8_audio_pkg::*;
#(
  parameter int PDM_COUNT_PERIOD = PDM_COUNT_PERIOD_DFLT,
  parameter int NUM_PDM_SAMPLES  = NUM_PDM_SAMPLES_DFLT,
  parameter int COUNT_W          = $clog2(NUM_PDM_SAMPLES) + 1
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic enable_in,
  input  logic mic_data_in,
  output logic mic_clk_out,
  output pcm_t sample_out,
  output logic sample_valid_out,
  input  logic sample_ready_in,
  output logic overrun_out,
  input  logic clear_overrun_in
);

  localparam int TICK_W = $clog2(NUM_PDM_SAMPLES);
  localparam int SHIFT  = TICK_W - 8;
  localparam logic [TICK_W-1:0] LAST_TICK = TICK_W'(NUM_PDM_SAMPLES - 1);

  dec_state_t          state;
  logic [1:0]          mic_sync;
  logic                mic_bit;
  logic                pdm_tick;
  logic [TICK_W-1:0]   tick_cnt;
  logic [COUNT_W-1:0]  ones_cnt;
  logic [COUNT_W-1:0]  window_ones;
  logic [8:0]          scaled;
  logic signed [9:0]   pcm_wide;
  pcm_t                pcm;
  logic                window_end;
  logic                new_sample;
  logic                can_load;

  chip8_mic_clk_gen #(
    .PDM_COUNT_PERIOD(PDM_COUNT_PERIOD)
  ) u_clk_gen (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .enable_in  (enable_in),
    .mic_clk_out(mic_clk_out),
    .pdm_tick   (pdm_tick)
  );

  // mic_data_in has no timing relation to clk_in.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) mic_sync <= '0;
    else         mic_sync <= {mic_sync[0], mic_data_in};
  end

  assign mic_bit = mic_sync[1];

  // The closing tick's bit is folded in before conversion.
  assign window_ones = ones_cnt + COUNT_W'(mic_bit);
  assign scaled      = 9'(window_ones >> SHIFT);
  assign pcm_wide    = $signed({1'b0, scaled}) - 10'sd128;
  assign pcm         = saturate_pcm(pcm_wide);

  assign window_end = pdm_tick && (tick_cnt == LAST_TICK);
  assign new_sample = window_end && (state == RUN);
  assign can_load   = !sample_valid_out || sample_ready_in;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state            <= DISABLED;
      tick_cnt         <= '0;
      ones_cnt         <= '0;
      sample_out       <= '0;
      sample_valid_out <= 1'b0;
      overrun_out      <= 1'b0;
    end else begin
      // A same-cycle overrun below overrides this clear.
      if (clear_overrun_in) overrun_out <= 1'b0;

      if (!enable_in) begin
        state            <= DISABLED;
        tick_cnt         <= '0;
        ones_cnt         <= '0;
        sample_valid_out <= 1'b0;
      end else begin
        if (state == DISABLED) begin
          state <= WARMUP;
        end else if (pdm_tick) begin
          if (window_end) begin
            tick_cnt <= '0;
            ones_cnt <= '0;
            state    <= RUN;
          end else begin
            tick_cnt <= tick_cnt + TICK_W'(1);
            ones_cnt <= window_ones;
          end
        end

        if (new_sample && can_load) begin
          sample_out       <= pcm;
          sample_valid_out <= 1'b1;
        end else if (new_sample) begin
          overrun_out <= 1'b1;
        end else if (sample_valid_out && sample_ready_in) begin
          sample_valid_out <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_chip8_pdm_decimator.sv
// Randomized self-checking bench: drives a PDM pattern per mic-clock tick and
// predicts each window's PCM value from the count of ones it drove.
`timescale 1ns/1ps
module tb_chip8_pdm_decimator;

  localparam int P         = 4;
  localparam int N         = 256;
  localparam int CW        = $clog2(N) + 1;
  localparam int WIN       = N * P;
  localparam int MAXW      = 16;
  localparam int FIRST_LAT = 2 + (2 * N - 1) * P;

  logic              clk_in = 1'b0;
  logic              rst_in = 1'b1;
  logic              enable_in = 1'b0;
  logic              mic_data_in = 1'b0;
  logic              sample_ready_in = 1'b0;
  logic              clear_overrun_in = 1'b0;
  logic              mic_clk_out;
  logic signed [7:0] sample_out;
  logic              sample_valid_out;
  logic              overrun_out;

  chip8_pdm_decimator #(
    .PDM_COUNT_PERIOD(P),
    .NUM_PDM_SAMPLES (N),
    .COUNT_W         (CW)
  ) dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .enable_in       (enable_in),
    .mic_data_in     (mic_data_in),
    .mic_clk_out     (mic_clk_out),
    .sample_out      (sample_out),
    .sample_valid_out(sample_valid_out),
    .sample_ready_in (sample_ready_in),
    .overrun_out     (overrun_out),
    .clear_overrun_in(clear_overrun_in)
  );

  always #5 clk_in = ~clk_in;

  int unsigned cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Reference model: per-session tick numbering and ones per window.
  int          mode;          // 0 zeros, 1 ones, 2 alternate, 3 quarter, 4 random
  int unsigned tick_idx;
  int unsigned win_ones[MAXW];
  int unsigned win_dens;
  bit          sess_active = 1'b0;

  function automatic int expected_pcm(input int unsigned ones);
    int v;
    v = int'(ones) * 256 / N - 128;
    if (v > 127) v = 127;
    return v;
  endfunction

  task automatic drive_bit(input int unsigned k);
    bit b;
    if (mode == 4 && k % N == 0) win_dens = $urandom_range(0, 256);
    case (mode)
      0:       b = 1'b0;
      1:       b = 1'b1;
      2:       b = (k % 2 == 0);
      3:       b = (k % 4 == 0);
      default: b = ($urandom_range(0, 255) < win_dens);
    endcase
    mic_data_in = b;
    if (b && (k / N) < MAXW) win_ones[k / N]++;
  endtask

  // After each falling mic clock, present the bit for the next rising edge.
  initial begin : mic_driver
    bit prev;
    prev = 1'b0;
    forever begin
      @(negedge clk_in);
      if (sess_active && prev && mic_clk_out === 1'b0) begin
        tick_idx++;
        drive_bit(tick_idx);
      end
      prev = sess_active ? (mic_clk_out === 1'b1) : 1'b0;
    end
  end

  task automatic start_session(input int m, output int unsigned c0);
    enable_in   = 1'b0;
    sess_active = 1'b0;
    repeat (4) @(negedge clk_in);
    mode     = m;
    tick_idx = 0;
    foreach (win_ones[i]) win_ones[i] = 0;
    drive_bit(0);
    repeat (4) @(negedge clk_in);
    c0          = cyc;
    enable_in   = 1'b1;
    sess_active = 1'b1;
  endtask

  task automatic wait_valid(input string tag, input int budget, output int unsigned vc);
    int n;
    n = 0;
    while (sample_valid_out !== 1'b1 && n < budget) begin
      @(negedge clk_in);
      n++;
    end
    if (sample_valid_out !== 1'b1) check({tag, "_timeout"}, 0, 1);
    vc = cyc;
  endtask

  task automatic hold_until(input int unsigned target, inout int lows);
    while (cyc < target) begin
      @(negedge clk_in);
      if (sample_valid_out !== 1'b1) lows++;
    end
  endtask

  task automatic check_stream(input string tag, input int unsigned c0, input int count);
    int unsigned vc, prev_vc;
    prev_vc = 0;
    for (int s = 0; s < count; s++) begin
      wait_valid(tag, 2 * WIN + 16, vc);
      if (s == 0)
        check({tag, "_first_latency_ok"},
              (vc - c0 >= FIRST_LAT - 1) && (vc - c0 <= FIRST_LAT + 2), 1);
      else
        check({tag, "_spacing"}, vc - prev_vc, WIN);
      check({tag, "_sample"}, sample_out, expected_pcm(win_ones[s + 1]));
      check({tag, "_overrun"}, overrun_out, 0);
      @(negedge clk_in);
      check({tag, "_valid_drop"}, sample_valid_out, 0);
      prev_vc = vc;
    end
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int unsigned c0, vc;
    int n, hi, lo, ticks, lows;

    #2 rst_in = 1'b0;
    repeat (3) @(negedge clk_in);
    check("rst_mic_clk", mic_clk_out, 0);
    check("rst_sample", sample_out, 0);
    check("rst_valid", sample_valid_out, 0);
    check("rst_overrun", overrun_out, 0);
    rst_in = 1'b1;
    repeat (3) @(negedge clk_in);
    check("idle_mic_clk", mic_clk_out, 0);

    // All ones: clock shape, tick rate, warmup latency, saturation to 127.
    sample_ready_in = 1'b1;
    start_session(1, c0);
    n = 0;
    while (mic_clk_out !== 1'b1 && n < 4 * P) begin @(negedge clk_in); n++; end
    hi = 0;
    while (mic_clk_out === 1'b1 && hi < 4 * P) begin @(negedge clk_in); hi++; end
    lo = 0;
    while (mic_clk_out === 1'b0 && lo < 4 * P) begin @(negedge clk_in); lo++; end
    check("mic_clk_high_cycles", hi, P / 2);
    check("mic_clk_low_cycles", lo, P / 2);
    ticks = 0;
    repeat (8 * P) begin
      @(negedge clk_in);
      ticks += int'(dut.pdm_tick);
    end
    check("ticks_in_8_periods", ticks, 8);
    check_stream("ones", c0, 2);

    start_session(0, c0);
    check_stream("zeros", c0, 2);
    start_session(2, c0);
    check_stream("alternate", c0, 1);
    start_session(3, c0);
    check_stream("quarter", c0, 1);
    start_session(4, c0);
    check_stream("random", c0, 3);

    // Back-pressure: hold first sample, drop the second, coincident load on the third.
    sample_ready_in = 1'b0;
    lows = 0;
    start_session(4, c0);
    wait_valid("ovr", 2 * WIN + 16, vc);
    check("ovr_first_sample", sample_out, expected_pcm(win_ones[1]));
    hold_until(vc + WIN - 1, lows);
    check("ovr_before_drop", overrun_out, 0);
    clear_overrun_in = 1'b1;
    @(negedge clk_in);
    clear_overrun_in = 1'b0;
    check("ovr_set_beats_clear", overrun_out, 1);
    check("ovr_sample_held", sample_out, expected_pcm(win_ones[1]));
    hold_until(vc + 2 * WIN - 1, lows);
    sample_ready_in = 1'b1;
    @(negedge clk_in);
    sample_ready_in = 1'b0;
    check("coincident_valid", sample_valid_out, 1);
    check("coincident_sample", sample_out, expected_pcm(win_ones[3]));
    check("coincident_overrun_kept", overrun_out, 1);
    hold_until(vc + 2 * WIN + WIN / 2, lows);
    check("valid_never_dropped", lows, 0);

    // Mid-window disable.
    enable_in   = 1'b0;
    sess_active = 1'b0;
    @(negedge clk_in);
    check("disable_mic_clk", mic_clk_out, 0);
    check("disable_valid", sample_valid_out, 0);
    check("disable_overrun_kept", overrun_out, 1);
    clear_overrun_in = 1'b1;
    @(negedge clk_in);
    clear_overrun_in = 1'b0;
    check("overrun_cleared", overrun_out, 0);

    // Re-enable goes through warmup again; then an asynchronous reset mid-window.
    start_session(4, c0);
    wait_valid("reenable", 2 * WIN + 16, vc);
    check("reenable_latency_ok",
          (vc - c0 >= FIRST_LAT - 1) && (vc - c0 <= FIRST_LAT + 2), 1);
    check("reenable_sample", sample_out, expected_pcm(win_ones[1]));
    lows = 0;
    hold_until(vc + WIN + WIN / 2, lows);
    check("reenable_overrun", overrun_out, 1);
    @(posedge clk_in);
    #3;
    rst_in      = 1'b0;
    enable_in   = 1'b0;
    sess_active = 1'b0;
    #1;
    check("async_rst_mic_clk", mic_clk_out, 0);
    check("async_rst_sample", sample_out, 0);
    check("async_rst_valid", sample_valid_out, 0);
    check("async_rst_overrun", overrun_out, 0);
    @(negedge clk_in);
    rst_in = 1'b1;
    repeat (3) @(negedge clk_in);
    check("post_rst_mic_clk", mic_clk_out, 0);
    check("post_rst_valid", sample_valid_out, 0);
    sample_ready_in = 1'b1;
    start_session(1, c0);
    check_stream("post_rst", c0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
